// File: rtl/mul_div.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Encodings: mul_or_div_i 0=MUL 1=DIV; reg*_sign_i 1=signed 0=unsigned.
module mul_div #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 mul_or_div_i,
  input  logic [WIDTH-1:0]     dividend_i,
  input  logic [WIDTH-1:0]     divisor_i,
  input  logic                 reg1_sign_i,
  input  logic                 reg2_sign_i,
  input  logic                 cancel_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 done_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic OP_DIV = 1'b1;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     op1_q, op1_d;
  logic [WIDTH-1:0]     op2_q, op2_d;
  logic                 isDiv_q, isDiv_d;
  logic                 negA_q, negA_d;
  logic                 negB_q, negB_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic                 negA, negB;
  logic [WIDTH-1:0]     aMag, bMag;
  logic [WIDTH:0]       mulSum;
  logic [WIDTH+1:0]     divShift, divDiff;
  logic [WIDTH:0]       divRem;
  logic [2*WIDTH-1:0]   product, mulFixed;
  logic [WIDTH-1:0]     quoFixed, remFixed;

  assign negA = reg1_sign_i & dividend_i[WIDTH-1];
  assign negB = reg2_sign_i & divisor_i[WIDTH-1];
  assign aMag = negA ? -dividend_i : dividend_i;
  assign bMag = negB ? -divisor_i  : divisor_i;

  // Multiply: acc = {carry, hi, lo}; lo starts as the multiplier and shifts out LSB-first.
  assign mulSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, op1_q} & {(WIDTH+1){acc_q[0]}});

  // Divide: acc = {partial remainder (33b), dividend/quotient shift register}.
  assign divShift = acc_q[2*WIDTH:WIDTH-1];
  assign divDiff  = divShift - {2'b00, op2_q};
  assign divRem   = divDiff[WIDTH+1] ? divShift[WIDTH:0] : divDiff[WIDTH:0];

  assign product  = acc_q[2*WIDTH-1:0];
  assign mulFixed = (negA_q ^ negB_q) ? -product : product;
  assign quoFixed = (negA_q ^ negB_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign remFixed = negA_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      isDiv_q  <= 1'b0;
      negA_q   <= 1'b0;
      negB_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      isDiv_q  <= isDiv_d;
      negA_q   <= negA_d;
      negB_q   <= negB_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    isDiv_d  = isDiv_q;
    negA_d   = negA_q;
    negB_d   = negB_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          op1_d   = aMag;
          op2_d   = bMag;
          isDiv_d = (mul_or_div_i == OP_DIV);
          negA_d  = negA;
          negB_d  = negB;
          cnt_d   = '0;
          acc_d   = {{(WIDTH+1){1'b0}}, (mul_or_div_i == OP_DIV) ? aMag : bMag};
          // Divide-by-zero and signed overflow resolve without iterating.
          if (mul_or_div_i == OP_DIV && divisor_i == '0) begin
            result_d = {ALL_ONES, dividend_i};
            state_d  = DONE;
          end else if (mul_or_div_i == OP_DIV && reg1_sign_i && reg2_sign_i &&
                       dividend_i == MIN_INT && divisor_i == ALL_ONES) begin
            result_d = {MIN_INT, {WIDTH{1'b0}}};
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (isDiv_q) begin
          acc_d = {divRem, acc_q[WIDTH-2:0], ~divDiff[WIDTH+1]};
        end else begin
          acc_d = {1'b0, mulSum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        result_d = isDiv_q ? {quoFixed, remFixed} : mulFixed;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush abandons whatever is in flight and leaves the last result visible.
    if (cancel_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  assign result_o = result_q;
  assign done_o   = (state_q == DONE);
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_mul_div.sv
// Scoreboard testbench for mul_div: directed RV32M vectors, fast paths, cancel, reset, back-to-back.
module tb_mul_div;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        mul_or_div_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        reg1_sign_i;
  logic        reg2_sign_i;
  logic        cancel_i;
  logic [63:0] result_o;
  logic        done_o;
  logic        busy_o;

  mul_div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .mul_or_div_i (mul_or_div_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .reg1_sign_i  (reg1_sign_i),
    .reg2_sign_i  (reg2_sign_i),
    .cancel_i     (cancel_i),
    .result_o     (result_o),
    .done_o       (done_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    logic [63:0] result;
    int          doneCycle;
    string       name;
  } expT;

  expT sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cycleCount = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every done_o cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done actual=%h cycle=%0d required=no_pulse", result_o, cycleCount);
      end else begin
        expT e;
        e = sb.pop_front();
        checkOutput({e.name, "_result"}, result_o, e.result);
        checkOutput({e.name, "_latency"}, 64'(cycleCount), 64'(e.doneCycle));
      end
    end
  end

  // Drives one operation; preEdges is how many rising edges pass before the DUT samples it.
  task automatic applyStimulus(input string name, input logic isDiv, input logic [31:0] a,
                               input logic [31:0] b, input logic s1, input logic s2,
                               input logic [63:0] expRes, input int lat, input int preEdges,
                               input logic keepStart);
    expT e;
    int  n;
    mul_or_div_i = isDiv;
    dividend_i   = a;
    divisor_i    = b;
    reg1_sign_i  = s1;
    reg2_sign_i  = s2;
    start_i      = 1'b1;
    repeat (preEdges) @(posedge clk);
    #1;
    e.result    = expRes;
    e.doneCycle = cycleCount + lat - 1;
    e.name      = name;
    sb.push_back(e);
    n = 0;
    @(negedge clk);
    while (!done_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout actual=no_done required=done", name);
    end
    if (!keepStart) begin
      start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b0;
    start_i      = 1'b0;
    mul_or_div_i = 1'b0;
    dividend_i   = '0;
    divisor_i    = '0;
    reg1_sign_i  = 1'b0;
    reg2_sign_i  = 1'b0;
    cancel_i     = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_result", result_o, 64'h0);
    checkOutput("reset_done", 64'(done_o), 64'h0);
    checkOutput("reset_busy", 64'(busy_o), 64'h0);
    rst = 1'b1;
    @(negedge clk);

    applyStimulus("mulu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 34, 1, 1'b0);
    applyStimulus("mulh_ss",  1'b0, 32'hFFFF_FFF9, 32'd3,         1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 34, 1, 1'b0);
    applyStimulus("mulhsu",   1'b0, 32'hFFFF_FFFF, 32'd2,         1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 34, 1, 1'b0);
    applyStimulus("mulu_neg", 1'b0, 32'hFFFF_FFF9, 32'd3,         1'b0, 1'b0, 64'h0000_0002_FFFF_FFEB, 34, 1, 1'b0);
    applyStimulus("div_neg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,       1'b1, 1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 34, 1, 1'b0);
    applyStimulus("divu_100_7", 1'b1, 32'd100, 32'd7,             1'b0, 1'b0, {32'd14, 32'd2}, 34, 1, 1'b0);
    applyStimulus("div_7_neg2", 1'b1, 32'd7, 32'hFFFF_FFFE,       1'b1, 1'b1, {32'hFFFF_FFFD, 32'h1}, 34, 1, 1'b0);
    applyStimulus("div_by_zero", 1'b1, 32'h1234, 32'h0,          1'b1, 1'b1, {32'hFFFF_FFFF, 32'h1234}, 1, 1, 1'b0);
    applyStimulus("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, {32'h8000_0000, 32'h0}, 1, 1, 1'b0);
    applyStimulus("divu_big",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, {32'h0, 32'h8000_0000}, 34, 1, 1'b0);

    // cancel_i together with start_i in IDLE must not launch anything
    mul_or_div_i = 1'b1;
    dividend_i   = 32'd50;
    divisor_i    = 32'd5;
    start_i      = 1'b1;
    cancel_i     = 1'b1;
    @(negedge clk);
    checkOutput("cancel_beats_start_busy", 64'(busy_o), 64'h0);
    start_i  = 1'b0;
    cancel_i = 1'b0;
    @(negedge clk);

    // cancel in cycle T+10 of a divide, restart in T+11
    mul_or_div_i = 1'b1;
    dividend_i   = 32'hFFFF_FFF9;
    divisor_i    = 32'd2;
    reg1_sign_i  = 1'b1;
    reg2_sign_i  = 1'b1;
    start_i      = 1'b1;
    @(posedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    cancel_i = 1'b1;
    @(negedge clk);
    cancel_i = 1'b0;
    checkOutput("cancel_busy", 64'(busy_o), 64'h0);
    checkOutput("cancel_done", 64'(done_o), 64'h0);
    checkOutput("cancel_result_hold", result_o, {32'h0, 32'h8000_0000});
    applyStimulus("divu_after_cancel", 1'b1, 32'd1000, 32'd33, 1'b0, 1'b0, {32'd30, 32'd10}, 34, 1, 1'b0);

    // asynchronous reset in the middle of CALC
    mul_or_div_i = 1'b0;
    dividend_i   = 32'hFFFF_FFFF;
    divisor_i    = 32'hFFFF_FFFF;
    reg1_sign_i  = 1'b0;
    reg2_sign_i  = 1'b0;
    start_i      = 1'b1;
    repeat (10) @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b0;
    #1;
    checkOutput("midcalc_reset_result", result_o, 64'h0);
    checkOutput("midcalc_reset_done", 64'(done_o), 64'h0);
    checkOutput("midcalc_reset_busy", 64'(busy_o), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // start_i held through DONE, new operands presented during DONE
    applyStimulus("b2b_first",  1'b0, 32'd6, 32'd7, 1'b0, 1'b0, 64'd42, 34, 1, 1'b1);
    applyStimulus("b2b_second", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, {32'hFFFF_FFF2, 32'hFFFF_FFFE}, 34, 2, 1'b0);

    repeat (40) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
